// File: rtl/branch_predictor.sv
// BTB + BHT branch predictor: zero-latency combinational lookup of pc_if, trained one edge after a resolve.
// No backpressure: one lookup and one update every cycle; clear drops a same-cycle update but still counts it.
module branch_predictor #(
  parameter int ENTRIES  = 64,
  parameter int TAG_BITS = 8,
  parameter int CNT_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [31:0]       pc_if,
  output logic              hit,
  output logic              pred_taken,
  output logic [31:0]       pred_pc,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_pc,
  output logic              mispred,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS - 1));
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

  logic [IDX_W-1:0]    lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                up_hit;
  logic [31:0]         correct_pc;
  logic [CNT_BITS-1:0] cnt_upd;
  logic                unused_pc;

  assign lk_idx = pc_if[IDX_W+1:2];
  assign lk_tag = pc_if[TAG_LO+TAG_BITS-1:TAG_LO];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[TAG_LO+TAG_BITS-1:TAG_LO];
  assign unused_pc = ^{pc_if, upd_pc};

  // Lookup sees only registered state, so a same-cycle update to this index is not bypassed.
  assign hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken = hit && cnt_q[lk_idx][CNT_BITS-1];
  assign pred_pc    = pred_taken ? target_q[lk_idx] : pc_if + 32'd4;

  assign correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;
  assign mispred    = upd_en && ((upd_pred_taken != upd_taken) || (upd_pred_pc != correct_pc));

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    cnt_upd = cnt_q[up_idx];
    if (upd_taken) begin
      if (cnt_q[up_idx] != CNT_MAX) cnt_upd = cnt_q[up_idx] + CNT_BITS'(1);
    end else if (cnt_q[up_idx] != '0) begin
      cnt_upd = cnt_q[up_idx] - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd_en) begin
      if (up_hit) begin
        cnt_q[up_idx] <= cnt_upd;
        if (upd_taken) target_q[up_idx] <= upd_target;
      end else if (upd_taken) begin
        // Miss on a taken branch evicts whatever aliased into this slot.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        cnt_q[up_idx]    <= CNT_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (upd_en && (stat_branches != '1)) stat_branches <= stat_branches + STAT_W'(1);
      if (mispred && (stat_mispred != '1)) stat_mispred <= stat_mispred + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised + directed bench for branch_predictor against an abstract table model.
module tb_branch_predictor;
  localparam int ENT = 64;
  localparam int IDXW = 6;
  localparam int CMAX = 3;

  logic clk, rst, clear, hit, pred_taken, mispred;
  logic [31:0] pc_if, pred_pc, upd_pc, upd_target, upd_pred_pc;
  logic upd_en, upd_taken, upd_pred_taken;
  logic [31:0] stat_branches, stat_mispred;

  logic rst4, clear4, hit4, pred_taken4, mispred4;
  logic [31:0] pc_if4, pred_pc4, upd_pc4, upd_target4, upd_pred_pc4;
  logic upd_en4, upd_taken4, upd_pred_taken4;
  logic [3:0] stat_branches4, stat_mispred4;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one record per slot, with plain integer counters.
  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_cnt   [ENT];
  longint      m_br, m_mp;

  branch_predictor dut (
    .clk(clk), .rst(rst), .clear(clear), .pc_if(pc_if), .hit(hit), .pred_taken(pred_taken),
    .pred_pc(pred_pc), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
    .mispred(mispred), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  branch_predictor #(.STAT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .clear(clear4), .pc_if(pc_if4), .hit(hit4), .pred_taken(pred_taken4),
    .pred_pc(pred_pc4), .upd_en(upd_en4), .upd_pc(upd_pc4), .upd_taken(upd_taken4),
    .upd_target(upd_target4), .upd_pred_taken(upd_pred_taken4), .upd_pred_pc(upd_pred_pc4),
    .mispred(mispred4), .stat_branches(stat_branches4), .stat_mispred(stat_mispred4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned m_idx(input logic [31:0] pc);
    return (pc >> 2) % ENT;
  endfunction

  function automatic int unsigned m_tg(input logic [31:0] pc);
    return (pc >> (IDXW + 2)) % 256;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tg(pc));
  endfunction

  function automatic bit m_ptak(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ppc(input logic [31:0] pc);
    return m_ptak(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_misp();
    logic [31:0] nxt;
    nxt = upd_taken ? upd_target : upd_pc + 32'd4;
    return upd_en && ((upd_pred_taken != upd_taken) || (upd_pred_pc != nxt));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    m_br = 0; m_mp = 0;
  endtask

  task automatic model_update();
    int unsigned i;
    bit mp;
    mp = m_misp();
    i = m_idx(upd_pc);
    if (clear) begin
      for (int k = 0; k < ENT; k++) m_valid[k] = 0;
    end else if (upd_en) begin
      if (m_hit(upd_pc)) begin
        if (upd_taken) begin
          m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
          m_tgt[i] = upd_target;
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1; m_tag[i] = m_tg(upd_pc); m_tgt[i] = upd_target; m_cnt[i] = 2;
      end
    end
    if (upd_en && m_br < 64'hFFFF_FFFF) m_br++;
    if (mp && m_mp < 64'hFFFF_FFFF) m_mp++;
  endtask

  task automatic check_now();
    #3;
    chk("hit", hit, m_hit(pc_if));
    chk("pred_taken", pred_taken, m_ptak(pc_if));
    chk("pred_pc", pred_pc, m_ppc(pc_if));
    chk("mispred", mispred, m_misp());
    chk("stat_branches", stat_branches, m_br);
    chk("stat_mispred", stat_mispred, m_mp);
  endtask

  task automatic clock();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_upd(input bit en, input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                         input bit use_model, input bit ptk, input logic [31:0] ppc);
    upd_en = en; upd_pc = pc; upd_taken = tk; upd_target = tg;
    upd_pred_taken = use_model ? m_ptak(pc) : ptk;
    upd_pred_pc    = use_model ? m_ppc(pc) : ppc;
  endtask

  task automatic idle();
    set_upd(0, 0, 0, 0, 0, 0, 0);
    clear = 0;
  endtask

  initial begin
    rst = 0; clear = 0; pc_if = 32'h40;
    idle();
    rst4 = 0; clear4 = 0; pc_if4 = 32'h40; upd_en4 = 0; upd_pc4 = 0; upd_taken4 = 0;
    upd_target4 = 0; upd_pred_taken4 = 0; upd_pred_pc4 = 0;
    model_reset();
    #1;
    check_now();
    chk("reset_ppc", pred_pc, 32'h44);
    @(negedge clk);
    rst = 1; rst4 = 1;
    @(posedge clk); #1;

    pc_if = 32'h40; check_now();
    chk("idle_hit", hit, 0); chk("idle_ppc", pred_pc, 32'h44); clock();

    set_upd(1, 32'h40, 1, 32'h100, 0, 0, 32'h44); check_now();
    chk("first_misp", mispred, 1); clock();

    idle(); check_now();
    chk("alloc_hit", hit, 1); chk("alloc_ptk", pred_taken, 1); chk("alloc_ppc", pred_pc, 32'h100);
    chk("alloc_br", stat_branches, 1); chk("alloc_mp", stat_mispred, 1); clock();

    repeat (2) begin set_upd(1, 32'h40, 1, 32'h100, 1, 0, 0); check_now(); clock(); end
    for (int n = 0; n < 5; n++) begin
      set_upd(1, 32'h40, 0, 0, 1, 0, 0); check_now(); clock();
      idle(); check_now();
      if (n == 0) chk("decay_wt", pred_taken, 1);
      if (n == 1) begin chk("decay_wnt", pred_taken, 0); chk("decay_ppc", pred_pc, 32'h44); end
      clock();
    end

    pc_if = 32'h140; check_now(); chk("alias_miss", hit, 0); clock();
    set_upd(1, 32'h140, 1, 32'h200, 1, 0, 0); check_now(); clock();
    idle(); check_now(); chk("alias_hit", hit, 1); chk("alias_ppc", pred_pc, 32'h200); clock();
    pc_if = 32'h40; check_now(); chk("alias_evict", hit, 0); clock();

    clear = 1; set_upd(1, 32'h80, 1, 32'h300, 1, 0, 0); check_now(); clock();
    idle(); pc_if = 32'h80; check_now(); chk("clear_drop", hit, 0); clock();
    pc_if = 32'h140; check_now(); chk("clear_all", hit, 0); clock();

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 2) << 8);
      if ($urandom_range(0, 9) == 0) p = $urandom;
      pc_if = ($urandom_range(0, 1) != 0) ? p : (($urandom_range(0, 7) << 2) | ($urandom_range(0, 2) << 8));
      clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) != 0)
        set_upd(1, p, $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, 1, 0, 0);
      else
        set_upd($urandom_range(0, 3) != 0, p, $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC,
                0, $urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? p + 32'd4 : $urandom);
      check_now();
      clock();
    end
    idle();

    // Narrow statistics instance: saturation, then reset asserted mid-cycle.
    upd_en4 = 1; upd_pc4 = 32'h40; upd_taken4 = 1; upd_target4 = 32'h100;
    upd_pred_taken4 = 0; upd_pred_pc4 = 32'h44;
    for (int n = 0; n < 20; n++) begin
      #3; chk("sat_misp", mispred4, 1);
      @(posedge clk); #1;
    end
    upd_en4 = 0;
    #1;
    chk("sat_mp", stat_mispred4, 15);
    chk("sat_br", stat_branches4, 15);
    chk("sat_hit", hit4, 1);
    rst4 = 0;
    #1;
    chk("arst_mp", stat_mispred4, 0);
    chk("arst_br", stat_branches4, 0);
    chk("arst_hit", hit4, 0);
    chk("arst_ppc", pred_pc4, 32'h44);
    @(posedge clk); #1;
    rst4 = 1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
